// File: rtl/vcm_pkg.sv
// Shared types and helpers for the value change monitor: event record and channel-index width.
package vcm_pkg;

  localparam int unsigned CHAN_MAXW = 4;
  localparam int unsigned DATA_MAXW = 64;

  typedef struct packed {
    logic [CHAN_MAXW-1:0] chan;
    logic [DATA_MAXW-1:0] data;
  } vcm_event_t;

  // Channel index width; a single channel still gets one bit.
  function automatic int unsigned chan_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/vcm_fifo.sv
// Event FIFO with wrap-bit pointers; simultaneous push and pop are honoured even when full.
module vcm_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/value_change_monitor.sv
// Watches NCH channels for 4-state value changes, counts them, and queues one event per
// pending channel through a lowest-index arbiter into an event FIFO.
module value_change_monitor
  import vcm_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NCH*WIDTH-1:0]    value,
  output logic [NCH*WIDTH-1:0]    monitor,
  output logic [NCH*CNTW-1:0]     chg_count,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [chan_w(NCH)-1:0]  ev_chan,
  output logic [WIDTH-1:0]        ev_data,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int unsigned CW = chan_w(NCH);
  localparam int unsigned PW = CW + WIDTH;

  logic [NCH*WIDTH-1:0] monitor_q, monitor_d;
  logic [NCH*CNTW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]       pending_q, pending_d;
  logic                 primed_q, primed_d;
  logic                 ovf_q, ovf_d;

  logic                 arb_found;
  logic [CW-1:0]        arb_chan;
  logic [WIDTH-1:0]     arb_data;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PW-1:0]        push_payload, head_payload;
  vcm_event_t           head_ev;

  // Lowest-index pending channel wins; pending_q only holds bits set on earlier edges.
  always_comb begin
    arb_found = 1'b0;
    arb_chan  = '0;
    arb_data  = '0;
    for (int c = int'(NCH) - 1; c >= 0; c--) begin
      if (pending_q[c]) begin
        arb_found = 1'b1;
        arb_chan  = CW'(c);
        arb_data  = monitor_q[c*WIDTH +: WIDTH];
      end
    end
  end

  assign fifo_pop     = !fifo_empty && ev_ready;
  assign fifo_push    = arb_found && (!fifo_full || fifo_pop);
  assign push_payload = {arb_chan, arb_data};

  always_comb begin
    monitor_d = monitor_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    primed_d  = primed_q;
    ovf_d     = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (fifo_push) begin
      pending_d[arb_chan] = 1'b0;
    end
    if (en) begin
      if (!primed_q) begin
        monitor_d = value;
        primed_d  = 1'b1;
      end else begin
        for (int unsigned c = 0; c < NCH; c++) begin
          // Case inequality so that X/Z transitions register as changes.
          if (value[c*WIDTH +: WIDTH] !== monitor_q[c*WIDTH +: WIDTH]) begin
            monitor_d[c*WIDTH +: WIDTH] = value[c*WIDTH +: WIDTH];
            if (cnt_q[c*CNTW +: CNTW] != {CNTW{1'b1}}) begin
              cnt_d[c*CNTW +: CNTW] = cnt_q[c*CNTW +: CNTW] + CNTW'(1);
            end
            if (pending_q[c] && !(fifo_push && (arb_chan == CW'(c)))) begin
              ovf_d = 1'b1;
            end
            pending_d[c] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      monitor_q <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      primed_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      monitor_q <= monitor_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      primed_q  <= primed_d;
      ovf_q     <= ovf_d;
    end
  end

  vcm_fifo #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (push_payload),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (head_payload)
  );

  always_comb begin
    head_ev.chan = CHAN_MAXW'(head_payload[PW-1 -: CW]);
    head_ev.data = DATA_MAXW'(head_payload[WIDTH-1:0]);
  end

  assign monitor   = monitor_q;
  assign chg_count = cnt_q;
  assign overflow  = ovf_q;
  assign ev_valid  = !fifo_empty;
  assign ev_chan   = CW'(head_ev.chan);
  assign ev_data   = WIDTH'(head_ev.data);

endmodule
